sqrt_share_ctrl: RTL

//  Shares one 12-cycle pipelined 48-bit integer square-root unit between NREQ requesters.

---
 rtl/sqrt_share_ctrl_if.sv | 23 ++
 rtl/sqrt_share_ctrl.sv | 111 +++++++++++
 2 files changed

// File: rtl/sqrt_share_ctrl_if.sv
// rtl/sqrt_share_ctrl_if.sv - request/response handshake bundle for the shared sqrt controller
interface sqrt_share_ctrl_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_vld;
    logic [NREQ*48-1:0] req_data;
    logic [NREQ-1:0]    req_rdy;
    logic               rsp_vld;
    logic [23:0]        rsp_data;
    logic [IDW-1:0]     rsp_id;
    logic               rsp_rdy;

    modport master (
        output req_vld, req_data, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_data, rsp_id
    );

    modport slave (
        input  req_vld, req_data, rsp_rdy,
        output req_rdy, rsp_vld, rsp_data, rsp_id
    );
endinterface

// File: rtl/sqrt_share_ctrl.sv
// rtl/sqrt_share_ctrl.sv - round-robin, credit-gated sharing of one pipelined sqrt unit
module sqrt_share_ctrl #(
    parameter int NREQ      = 4,
    parameter int LAT       = 12,
    parameter int OUT_DEPTH = 16,
    parameter int IDW       = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    sqrt_share_ctrl_if.slave   bus,
    output logic [47:0]        sq_src,
    output logic               sq_vldin,
    output logic               sq_en,
    input  logic [23:0]        sq_out,
    input  logic               sq_vldout,
    output logic               err_sticky
);
    localparam int CW = $clog2(OUT_DEPTH + 1);
    localparam int WW = $clog2(LAT + 1);
    localparam int AW = $clog2(OUT_DEPTH);

    logic [WW-1:0]     warm_q, warm_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]     credits_q, credits_d;
    logic [LAT-1:0]    tag_vld_q, tag_vld_d;
    logic [IDW-1:0]    tag_id_q [LAT];
    logic [IDW-1:0]    tag_id_d [LAT];
    logic [IDW+23:0]   mem_q [OUT_DEPTH];
    logic [IDW+23:0]   mem_d [OUT_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              err_q, err_d;

    logic              warm_done, grant_en, issue, found, wr, pop;
    logic [IDW-1:0]    gid;
    logic [NREQ-1:0]   grant;

    assign warm_done = (warm_q == WW'(LAT));
    // rst_n gating keeps every output quiet in the reset cycle itself
    assign grant_en  = rst_n && warm_done && (credits_q != '0);

    always_comb begin
        found = 1'b0;
        gid   = '0;
        grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && grant_en && bus.req_vld[(int'(ptr_q) + i) % NREQ]) begin
                found = 1'b1;
                gid   = IDW'((int'(ptr_q) + i) % NREQ);
            end
        end
        if (found) grant[gid] = 1'b1;
    end

    assign issue       = found;
    assign bus.req_rdy = grant;
    assign sq_vldin    = issue;
    assign sq_src      = issue ? bus.req_data[48*int'(gid) +: 48] : 48'd0;
    assign sq_en       = 1'b1;

    assign wr          = tag_vld_q[LAT-1];
    assign bus.rsp_vld = rst_n && (count_q != '0);
    assign pop         = bus.rsp_vld && bus.rsp_rdy;
    assign bus.rsp_id  = mem_q[rd_ptr_q][IDW+23:24];
    assign bus.rsp_data = mem_q[rd_ptr_q][23:0];
    assign err_sticky  = err_q;

    always_comb begin
        warm_d    = warm_done ? warm_q : warm_q + WW'(1);
        ptr_d     = issue ? IDW'((int'(gid) + 1) % NREQ) : ptr_q;
        credits_d = credits_q - CW'(issue) + CW'(pop);
        tag_vld_d = {tag_vld_q[LAT-2:0], issue};
        tag_id_d[0] = gid;
        for (int i = 1; i < LAT; i++) tag_id_d[i] = tag_id_q[i-1];
        // data follows the tag even when the unit's valid disagrees
        err_d     = err_q | (warm_done && (sq_vldout != wr));
        mem_d     = mem_q;
        if (wr) mem_d[wr_ptr_q] = {tag_id_q[LAT-1], sq_out};
        wr_ptr_d  = wr_ptr_q + AW'(wr);
        rd_ptr_d  = rd_ptr_q + AW'(pop);
        count_d   = count_q + CW'(wr) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            warm_q    <= '0;
            ptr_q     <= '0;
            credits_q <= CW'(OUT_DEPTH);
            tag_vld_q <= '0;
            for (int i = 0; i < LAT; i++) tag_id_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            warm_q    <= warm_d;
            ptr_q     <= ptr_d;
            credits_q <= credits_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule
